// File: rtl/alu_mdu.sv
// EX-stage ALU with a multi-cycle multiply/divide unit, HI/LO registers and a
// Start/Busy handshake. MD results come from a combinational core gated by a latency counter.
module alu_mdu #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Op,
    input  logic             Start,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_AND   = 5'd2;
    localparam logic [4:0] OP_OR    = 5'd3;
    localparam logic [4:0] OP_SRL   = 5'd4;
    localparam logic [4:0] OP_SRA   = 5'd5;
    localparam logic [4:0] OP_SLL   = 5'd6;
    localparam logic [4:0] OP_SLT   = 5'd7;
    localparam logic [4:0] OP_SLTU  = 5'd8;
    localparam logic [4:0] OP_NOR   = 5'd9;
    localparam logic [4:0] OP_XOR   = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;
    localparam logic [4:0] OP_MTHI  = 5'd17;
    localparam logic [4:0] OP_MTLO  = 5'd18;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] la, lb;
    logic [4:0]       lop;

    logic [WIDTH-1:0] sum, diff;
    logic [SHW-1:0]   sh;

    assign sum  = A + B;
    assign diff = A - B;
    assign sh   = A[SHW-1:0];

    // Combinational ALU result
    always_comb begin
        Out = '0;
        case (Op)
            OP_ADD:  Out = sum;
            OP_SUB:  Out = diff;
            OP_AND:  Out = A & B;
            OP_OR:   Out = A | B;
            OP_SRL:  Out = B >> sh;
            OP_SRA:  Out = $unsigned($signed(B) >>> sh);
            OP_SLL:  Out = B << sh;
            OP_SLT:  Out = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
            OP_SLTU: Out = (A < B) ? WIDTH'(1) : '0;
            OP_NOR:  Out = ~(A | B);
            OP_XOR:  Out = A ^ B;
            OP_MFHI: Out = HI;
            OP_MFLO: Out = LO;
            default: Out = '0;
        endcase
    end

    assign Zero = (Out == '0);

    // Signed overflow: result sign disagrees with what the operand signs imply
    always_comb begin
        Overflow = 1'b0;
        if (Op == OP_ADD)
            Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
        else if (Op == OP_SUB)
            Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
    end

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic [WIDTH-1:0]   abs_a, abs_b, sdiv, udiv;
    logic [WIDTH-1:0]   q_mag, r_mag, q_s, r_s, q_u, r_u;

    assign prod_s = {{WIDTH{la[WIDTH-1]}}, la} * {{WIDTH{lb[WIDTH-1]}}, lb};
    assign prod_u = {WIDTH'(0), la} * {WIDTH'(0), lb};

    // Signed divide on magnitudes; most-negative / -1 wraps naturally to most-negative
    assign abs_a = la[WIDTH-1] ? (~la + WIDTH'(1)) : la;
    assign abs_b = lb[WIDTH-1] ? (~lb + WIDTH'(1)) : lb;
    assign sdiv  = (abs_b == '0) ? WIDTH'(1) : abs_b;
    assign udiv  = (lb == '0) ? WIDTH'(1) : lb;
    assign q_mag = abs_a / sdiv;
    assign r_mag = abs_a % sdiv;
    assign q_s   = (la[WIDTH-1] ^ lb[WIDTH-1]) ? (~q_mag + WIDTH'(1)) : q_mag;
    assign r_s   = la[WIDTH-1] ? (~r_mag + WIDTH'(1)) : r_mag;
    assign q_u   = la / udiv;
    assign r_u   = la % udiv;

    assign Busy = (state == RUN);

    // MD sequencer: latch operands on Start, commit HI/LO when the counter expires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            la    <= '0;
            lb    <= '0;
            lop   <= '0;
            Done  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (Op >= OP_MULT && Op <= OP_DIVU) begin
                            la    <= A;
                            lb    <= B;
                            lop   <= Op;
                            cnt   <= (Op <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                            state <= RUN;
                        end else if (Op == OP_MTHI) begin
                            HI <= A;
                        end else if (Op == OP_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        Done  <= 1'b1;
                        case (lop)
                            OP_MULT:  {HI, LO} <= prod_s;
                            OP_MULTU: {HI, LO} <= prod_u;
                            OP_DIV: begin
                                if (lb != '0) begin
                                    LO <= q_s;
                                    HI <= r_s;
                                end
                            end
                            OP_DIVU: begin
                                if (lb != '0) begin
                                    LO <= q_u;
                                    HI <= r_u;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH=32, MULT 5 cycles, DIV 10 cycles).
module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [4:0]  Op;
    logic        Start;
    logic [31:0] Out, HI, LO;
    logic        Zero, Overflow, Busy, Done;

    int vectors     = 0;
    int miscompares = 0;

    alu_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .Start(Start),
        .Out(Out), .Zero(Zero), .Overflow(Overflow), .Busy(Busy), .Done(Done),
        .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eout, input string tag);
        Op = op; A = a; B = b;
        #1;
        chk(tag, Out, eout);
    endtask

    // Launch an MD op, scramble operands during RUN, and check the exact Busy/Done timing
    task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] ehi, input logic [31:0] elo,
                          input string tag);
        @(negedge clk);
        Op = op; A = a; B = b; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; Op = 5'd0; A = $urandom; B = $urandom;
        chk({tag, "_busy_first"}, {31'b0, Busy}, 32'd1);
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            chk({tag, "_busy_run"}, {31'b0, Busy}, 32'd1);
            chk({tag, "_done_early"}, {31'b0, Done}, 32'd0);
        end
        @(negedge clk);
        chk({tag, "_busy_end"}, {31'b0, Busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, Done}, 32'd1);
        chk({tag, "_hi"}, HI, ehi);
        chk({tag, "_lo"}, LO, elo);
        Op = 5'd15;
        #1;
        chk({tag, "_mfhi"}, Out, ehi);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, Done}, 32'd0);
    endtask

    initial begin
        int done_seen;
        reset = 1'b1; A = '0; B = '0; Op = '0; Start = 1'b0;
        #2;
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Combinational sweep
        alu(5'd0, 32'd7, 32'd5, 32'd12, "add");
        alu(5'd1, 32'd7, 32'd5, 32'd2, "sub");
        alu(5'd2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, "and");
        alu(5'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, "or");
        alu(5'd4, 32'd4, 32'h8000_0000, 32'h0800_0000, "srl");
        alu(5'd5, 32'd4, 32'h8000_0000, 32'hF800_0000, "sra");
        alu(5'd6, 32'd4, 32'd1, 32'h0000_0010, "sll");
        alu(5'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
        alu(5'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
        alu(5'd9, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, "nor");
        alu(5'd10, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, "xor");
        alu(5'd11, 32'd7, 32'd5, 32'd0, "mult_out_zero");
        alu(5'd20, 32'd7, 32'd5, 32'd0, "undef_out_zero");
        alu(5'd1, 32'd5, 32'd5, 32'd0, "sub_eq");
        chk("zero_flag", {31'b0, Zero}, 32'd1);
        alu(5'd0, 32'd7, 32'd5, 32'd12, "add_nz");
        chk("zero_clear", {31'b0, Zero}, 32'd0);

        // Overflow
        alu(5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_ovf_out");
        chk("add_ovf", {31'b0, Overflow}, 32'd1);
        alu(5'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, "sub_ovf_out");
        chk("sub_ovf", {31'b0, Overflow}, 32'd1);
        alu(5'd0, 32'd1, 32'd1, 32'd2, "add_small");
        chk("add_no_ovf", {31'b0, Overflow}, 32'd0);
        alu(5'd2, 32'h7FFF_FFFF, 32'd1, 32'd1, "and_no_ovf_out");
        chk("and_no_ovf", {31'b0, Overflow}, 32'd0);

        // Start with a non-MD op is ignored
        @(negedge clk);
        Op = 5'd0; A = 32'd1; B = 32'd2; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("nonmd_start_busy", {31'b0, Busy}, 32'd0);

        // Multiply / divide
        run_md(5'd11, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
        run_md(5'd12, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
        run_md(5'd13, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div");
        run_md(5'd14, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu_by0");
        run_md(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, "div_minneg");
        run_md(5'd14, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu");

        // Collisions during a MULT: DIV start and MTLO must be ignored
        @(negedge clk);
        Op = 5'd11; A = 32'd6; B = 32'd9; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("col_busy1", {31'b0, Busy}, 32'd1);
        @(negedge clk);
        Op = 5'd13; A = 32'd100; B = 32'd3; Start = 1'b1;
        @(negedge clk);
        Op = 5'd18; A = 32'h0000_DEAD;
        chk("col_busy3", {31'b0, Busy}, 32'd1);
        @(negedge clk);
        Start = 1'b0;
        chk("col_lo_kept", LO, 32'd14);
        chk("col_busy4", {31'b0, Busy}, 32'd1);
        @(negedge clk);
        chk("col_busy5", {31'b0, Busy}, 32'd1);
        @(negedge clk);
        chk("col_busy_end", {31'b0, Busy}, 32'd0);
        chk("col_done", {31'b0, Done}, 32'd1);
        chk("col_hi", HI, 32'd0);
        chk("col_lo", LO, 32'h0000_0036);
        @(negedge clk);
        chk("col_no_div", {31'b0, Busy}, 32'd0);
        chk("col_done_pulse", {31'b0, Done}, 32'd0);

        // MTHI while idle
        Op = 5'd17; A = 32'h0000_1234; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("mthi_hi", HI, 32'h0000_1234);
        chk("mthi_busy", {31'b0, Busy}, 32'd0);
        chk("mthi_done", {31'b0, Done}, 32'd0);

        // Asynchronous reset in the middle of a DIV
        Op = 5'd14; A = 32'd100; B = 32'd7; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, Busy}, 32'd0);
        chk("arst_done", {31'b0, Done}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (Done) done_seen++;
        end
        chk("arst_no_done", 32'(done_seen), 32'd0);
        chk("arst_lo_after", LO, 32'd0);
        run_md(5'd11, 32'd6, 32'd7, 5, 32'd0, 32'd42, "mult_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
